// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue: the buffered entry layout, the default
// region/reset addresses, and a constant-foldable ceil(log2) helper.
package fetch_queue_pkg;

  localparam int unsigned ADDR_W_DEF = 64;
  localparam int unsigned INST_W_DEF = 32;

  localparam logic [63:0] METAL_BASE_DEF = 64'hffff_ffff_ffff_0000;
  localparam logic [63:0] RESET_PC_DEF   = 64'h0;

  typedef struct packed {
    logic [INST_W_DEF-1:0] inst;
    logic [ADDR_W_DEF-1:0] pc;
    logic                  metal;
  } fetch_entry_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush. Head data is read combinationally from the read pointer;
// a push and a pop in the same cycle are both honoured even when full.
module sync_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_en, pop_en;

  always_comb begin
    pop_en  = pop & (count_q != '0) & ~flush;
    push_en = push & ((count_q != CNT_W'(DEPTH)) | pop_en) & ~flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, steers each fetch to the icache or metal memory
// by address range, and buffers tagged instructions for decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned      ADDR_W     = 64,
  parameter int unsigned      INST_W     = 32,
  parameter int unsigned      DEPTH      = 4,
  parameter logic [ADDR_W-1:0] METAL_BASE = ADDR_W'(METAL_BASE_DEF),
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF),
  localparam int unsigned     CNT_W      = clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] icache_addr,
  output logic              icache_rd_en,
  input  logic [INST_W-1:0] icache_data,
  input  logic              icache_stall,
  output logic [ADDR_W-1:0] metal_addr,
  output logic              metal_rd_en,
  input  logic [INST_W-1:0] metal_data,
  input  logic              metal_stall,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_metal,
  input  logic              inst_ready,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  localparam int unsigned ENTRY_W = INST_W + ADDR_W + 1;

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               sel_metal, sel_stall, fetch_en, push, pop;
  logic [ENTRY_W-1:0] push_entry, head_entry;
  logic [INST_W-1:0]  head_inst;
  logic [ADDR_W-1:0]  head_pc;
  logic               head_metal;

  always_comb begin
    sel_metal  = (fetch_pc_q >= METAL_BASE);
    sel_stall  = sel_metal ? metal_stall : icache_stall;
    pop        = inst_valid & inst_ready & ~redirect_valid;
    // Gating with rst keeps both read enables low for the whole reset window.
    fetch_en   = ~rst & ~redirect_valid & (~full | pop);
    push       = fetch_en & ~sel_stall;
    push_entry = {(sel_metal ? metal_data : icache_data), fetch_pc_q, sel_metal};

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    else if (push)      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_pc_q <= RESET_PC;
    else     fetch_pc_q <= fetch_pc_d;
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (push_entry),
    .rdata (head_entry),
    .count (count)
  );

  assign {head_inst, head_pc, head_metal} = head_entry;

  always_comb begin
    full         = (count == CNT_W'(DEPTH));
    inst_valid   = (count != '0);
    inst_out     = inst_valid ? head_inst : '0;
    inst_pc      = inst_valid ? head_pc : '0;
    inst_metal   = inst_valid & head_metal;
    icache_addr  = fetch_pc_q;
    metal_addr   = fetch_pc_q;
    icache_rd_en = fetch_en & ~sel_metal;
    metal_rd_en  = fetch_en & sel_metal;
  end

endmodule
